// File: rtl/prt_dptx_trn_pkg.sv
// Shared constants, training-pattern tables and helpers for the DP TX link-training pattern generator.
package prt_dptx_trn_pkg;

  typedef enum logic [2:0] {
    TPS_OFF = 3'd0,
    TPS_1   = 3'd1,
    TPS_2   = 3'd2,
    TPS_3   = 3'd3,
    TPS_4   = 3'd4
  } tps_t;

  // One link symbol as {k, dat}.
  typedef logic [8:0] sym_t;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] D11_6 = 8'hCB;
  localparam logic [7:0] D10_2 = 8'h4A;

  localparam int unsigned SEQ_LEN = 10;

  localparam sym_t PRT_DPTX_TRN_TPS2 [SEQ_LEN] = '{
    {1'b1, K28_5}, {1'b0, D11_6}, {1'b1, K28_5}, {1'b0, D11_6}, {1'b0, D10_2},
    {1'b0, D10_2}, {1'b0, D10_2}, {1'b0, D10_2}, {1'b0, D10_2}, {1'b0, D10_2}
  };

  localparam sym_t PRT_DPTX_TRN_TPS3 [SEQ_LEN] = '{
    {1'b1, K28_5}, {1'b0, D10_2}, {1'b0, D11_6}, {1'b0, D10_2}, {1'b1, K28_5},
    {1'b0, D11_6}, {1'b0, D10_2}, {1'b0, D10_2}, {1'b0, D11_6}, {1'b0, D11_6}
  };

  // Sequence position advanced by n symbols, wrapping mid-word when needed.
  function automatic logic [3:0] idx_add(input logic [3:0] idx, input int unsigned n);
    int unsigned s;
    s = int'(idx) + n;
    return 4'(s % SEQ_LEN);
  endfunction

  function automatic tps_t tps_decode(input logic [2:0] v);
    return (v <= 3'd4) ? tps_t'(v) : TPS_OFF;
  endfunction

  function automatic logic [2:0] lanes_decode(input logic [2:0] v);
    return (v == 3'd1 || v == 3'd2 || v == 3'd4) ? v : 3'd1;
  endfunction

endpackage

// File: rtl/prt_dptx_trn_lane.sv
// One lane of the training pattern generator: per-symbol source mux followed by the output register.
module prt_dptx_trn_lane
  import prt_dptx_trn_pkg::*;
#(
  parameter int P_SPL = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [3:0]         idx_i,
  input  tps_t               tps_i,
  input  logic               active_i,
  input  logic               inj_i,
  input  logic [P_SPL-1:0]   lnk_k_i,
  input  logic [P_SPL*8-1:0] lnk_dat_i,
  input  logic [P_SPL-1:0]   scrm_k_i,
  input  logic [P_SPL*8-1:0] scrm_dat_i,
  output logic [P_SPL-1:0]   k_o,
  output logic [P_SPL*8-1:0] dat_o
);

  logic [P_SPL-1:0]   k_d, k_q;
  logic [P_SPL*8-1:0] dat_d, dat_q;
  sym_t               sym;

  always_comb begin
    k_d   = '0;
    dat_d = '0;
    sym   = '0;
    if (active_i) begin
      for (int j = 0; j < P_SPL; j++) begin
        case (tps_i)
          TPS_OFF: sym = {lnk_k_i[j], lnk_dat_i[j*8 +: 8]};
          TPS_1:   sym = {1'b0, D10_2};
          TPS_2:   sym = PRT_DPTX_TRN_TPS2[idx_add(idx_i, unsigned'(j))];
          TPS_3:   sym = PRT_DPTX_TRN_TPS3[idx_add(idx_i, unsigned'(j))];
          TPS_4:   sym = {scrm_k_i[j], scrm_dat_i[j*8 +: 8]};
          default: sym = '0;
        endcase
        k_d[j]          = sym[8];
        dat_d[j*8 +: 8] = sym[7:0];
      end
      // Injected error flips the LSB of symbol 0 only.
      if (inj_i) dat_d[7:0] = dat_d[7:0] ^ 8'h01;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      k_q   <= '0;
      dat_q <= '0;
    end else begin
      k_q   <= k_d;
      dat_q <= dat_d;
    end
  end

  assign k_o   = k_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/prt_dptx_trn.sv
// DP TX link-training pattern generator top: config register, shared index counter and lane array.
// Optional error injection port is enabled by defining PRT_DPTX_TRN_ERR_INJ_EN.
module prt_dptx_trn
  import prt_dptx_trn_pkg::*;
#(
  parameter int P_LANES = 4,
  parameter int P_SPL   = 2
) (
  input  logic                       CLK_IN,
  input  logic                       RST_IN,
  input  logic                       CFG_SET_IN,
  input  logic [2:0]                 CFG_TPS_IN,
  input  logic [2:0]                 CFG_LANES_IN,
  input  logic [P_LANES*P_SPL-1:0]   LNK_K_IN,
  input  logic [P_LANES*P_SPL*8-1:0] LNK_DAT_IN,
  input  logic [P_LANES*P_SPL-1:0]   SCRM_K_IN,
  input  logic [P_LANES*P_SPL*8-1:0] SCRM_DAT_IN,
`ifdef PRT_DPTX_TRN_ERR_INJ_EN
  input  logic                       STA_ERR_INJ_IN,
`endif
  output logic [P_LANES*P_SPL-1:0]   LNK_K_OUT,
  output logic [P_LANES*P_SPL*8-1:0] LNK_DAT_OUT,
  output logic [2:0]                 STA_TPS_OUT
);

  tps_t       tps_q, tps_d;
  logic [2:0] lanes_q, lanes_d;
  logic [3:0] idx_q, idx_d;
  logic       inj;

  always_comb begin
    tps_d   = tps_q;
    lanes_d = lanes_q;
    idx_d   = 4'd0;
    if (CFG_SET_IN) begin
      tps_d   = tps_decode(CFG_TPS_IN);
      lanes_d = lanes_decode(CFG_LANES_IN);
    end else if (tps_q == TPS_2 || tps_q == TPS_3) begin
      idx_d = idx_add(idx_q, unsigned'(P_SPL));
    end
  end

  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      tps_q   <= TPS_OFF;
      lanes_q <= 3'd1;
      idx_q   <= 4'd0;
    end else begin
      tps_q   <= tps_d;
      lanes_q <= lanes_d;
      idx_q   <= idx_d;
    end
  end

`ifdef PRT_DPTX_TRN_ERR_INJ_EN
  assign inj = STA_ERR_INJ_IN && (tps_q == TPS_1 || tps_q == TPS_2 || tps_q == TPS_3);
`else
  assign inj = 1'b0;
`endif

  generate
    for (genvar gi = 0; gi < P_LANES; gi++) begin : g_lane
      prt_dptx_trn_lane #(.P_SPL(P_SPL)) u_lane (
        .clk_i      (CLK_IN),
        .rst_ni     (RST_IN),
        .idx_i      (idx_q),
        .tps_i      (tps_q),
        .active_i   (gi < int'(lanes_q)),
        .inj_i      ((gi == 0) ? inj : 1'b0),
        .lnk_k_i    (LNK_K_IN[gi*P_SPL +: P_SPL]),
        .lnk_dat_i  (LNK_DAT_IN[gi*P_SPL*8 +: P_SPL*8]),
        .scrm_k_i   (SCRM_K_IN[gi*P_SPL +: P_SPL]),
        .scrm_dat_i (SCRM_DAT_IN[gi*P_SPL*8 +: P_SPL*8]),
        .k_o        (LNK_K_OUT[gi*P_SPL +: P_SPL]),
        .dat_o      (LNK_DAT_OUT[gi*P_SPL*8 +: P_SPL*8])
      );
    end
  endgenerate

  assign STA_TPS_OUT = tps_q;

endmodule

// File: tb/tb_prt_dptx_trn.sv
// Directed bench for prt_dptx_trn: one P_SPL=2 and one P_SPL=4 instance sharing the config strobes.
module tb_prt_dptx_trn;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_set = 1'b0;
  logic [2:0]   cfg_tps = 3'd0;
  logic [2:0]   cfg_lanes = 3'd1;
  logic         err_inj = 1'b0;
  logic [7:0]   lnk_k2 = '0, scrm_k2 = '0, k2;
  logic [63:0]  lnk_dat2 = '0, scrm_dat2 = '0, dat2;
  logic [15:0]  lnk_k4 = '0, scrm_k4 = '0, k4;
  logic [127:0] lnk_dat4 = '0, scrm_dat4 = '0, dat4;
  logic [2:0]   sta2, sta4;
  int           total = 0;
  int           bad = 0;

  always #5 clk = ~clk;

  prt_dptx_trn #(.P_LANES(4), .P_SPL(2)) dut2 (
    .CLK_IN(clk), .RST_IN(rst_n), .CFG_SET_IN(cfg_set), .CFG_TPS_IN(cfg_tps),
    .CFG_LANES_IN(cfg_lanes), .LNK_K_IN(lnk_k2), .LNK_DAT_IN(lnk_dat2),
    .SCRM_K_IN(scrm_k2), .SCRM_DAT_IN(scrm_dat2),
`ifdef PRT_DPTX_TRN_ERR_INJ_EN
    .STA_ERR_INJ_IN(err_inj),
`endif
    .LNK_K_OUT(k2), .LNK_DAT_OUT(dat2), .STA_TPS_OUT(sta2)
  );

  prt_dptx_trn #(.P_LANES(4), .P_SPL(4)) dut4 (
    .CLK_IN(clk), .RST_IN(rst_n), .CFG_SET_IN(cfg_set), .CFG_TPS_IN(cfg_tps),
    .CFG_LANES_IN(cfg_lanes), .LNK_K_IN(lnk_k4), .LNK_DAT_IN(lnk_dat4),
    .SCRM_K_IN(scrm_k4), .SCRM_DAT_IN(scrm_dat4),
`ifdef PRT_DPTX_TRN_ERR_INJ_EN
    .STA_ERR_INJ_IN(err_inj),
`endif
    .LNK_K_OUT(k4), .LNK_DAT_OUT(dat4), .STA_TPS_OUT(sta4)
  );

  // Hand-computed TPS2 lane words: P_SPL=2 visits idx 0,2,4,6,8,0; P_SPL=4 visits 0,4,8,2,6,0.
  localparam logic [15:0] E2_DAT [6] = '{16'hCBBC, 16'hCBBC, 16'h4A4A, 16'h4A4A, 16'h4A4A, 16'hCBBC};
  localparam logic [1:0]  E2_K   [6] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01};
  localparam logic [31:0] E4_DAT [6] = '{32'hCBBCCBBC, 32'h4A4A4A4A, 32'hCBBC4A4A,
                                         32'h4A4ACBBC, 32'h4A4A4A4A, 32'hCBBCCBBC};
  localparam logic [3:0]  E4_K   [6] = '{4'b0101, 4'b0000, 4'b0100, 4'b0001, 4'b0000, 4'b0101};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [2:0] tps, input logic [2:0] lanes);
    cfg_tps   = tps;
    cfg_lanes = lanes;
    cfg_set   = 1'b1;
    tick();
    cfg_set   = 1'b0;
  endtask

  initial begin
    // Reset state, with a strobe that must be lost while reset is held.
    repeat (2) tick();
    cfg_tps = 3'd1; cfg_lanes = 3'd4; cfg_set = 1'b1;
    tick();
    cfg_set = 1'b0;
    chk("reset_dat2", dat2, 0);
    chk("reset_k2", k2, 0);
    chk("reset_dat4", dat4, 0);
    chk("reset_sta", sta2, 0);
    rst_n = 1'b1;
    tick();
    chk("strobe_in_reset_lost", sta2, 0);

    // Pass-through on lane 0 only, 1-cycle latency.
    lnk_dat2 = 64'h1817161514131211; lnk_k2 = 8'hA5;
    tick();
    chk("pass_dat_a", dat2, 64'h1211);
    chk("pass_k_a", k2, 8'h01);
    lnk_dat2 = 64'h2827262524232221; lnk_k2 = 8'h5A;
    tick();
    chk("pass_dat_b", dat2, 64'h2221);
    chk("pass_k_b", k2, 8'h02);

    // TPS1 on four lanes.
    set_cfg(3'd1, 3'd4);
    chk("tps1_sta", sta2, 3'd1);
    tick();
    chk("tps1_dat2", dat2, {8{8'h4A}});
    chk("tps1_k2", k2, 0);
    chk("tps1_dat4", dat4, {16{8'h4A}});

    // TPS2 sequence and mid-word wrap.
    set_cfg(3'd2, 3'd4);
    chk("tps2_sta", sta2, 3'd2);
    for (int w = 0; w < 6; w++) begin
      tick();
      chk($sformatf("tps2_spl2_w%0d_dat", w), dat2, {4{E2_DAT[w]}});
      chk($sformatf("tps2_spl2_w%0d_k", w), k2, {4{E2_K[w]}});
      chk($sformatf("tps2_spl4_w%0d_dat", w), dat4, {4{E4_DAT[w]}});
      chk($sformatf("tps2_spl4_w%0d_k", w), k4, {4{E4_K[w]}});
    end

    // Same-TPS reload restarts the index.
    set_cfg(3'd2, 3'd4);
    tick();
    chk("reload_dat2", dat2, {4{16'hCBBC}});
    chk("reload_dat4", dat4, {4{32'hCBBCCBBC}});

    // TPS3 first two words.
    set_cfg(3'd3, 3'd4);
    tick();
    chk("tps3_w0_dat", dat2, {4{16'h4ABC}});
    chk("tps3_w0_k", k2, {4{2'b01}});
    tick();
    chk("tps3_w1_dat", dat2, {4{16'h4ACB}});
    chk("tps3_w1_k", k2, 0);

    // TPS4 on two lanes.
    scrm_dat2 = 64'h8877665544332211; scrm_k2 = 8'hF3;
    set_cfg(3'd4, 3'd2);
    chk("tps4_sta", sta2, 3'd4);
    tick();
    chk("tps4_dat_a", dat2, 64'h44332211);
    chk("tps4_k_a", k2, 8'h03);
    scrm_dat2 = 64'h0F0E0D0C0B0A0908; scrm_k2 = 8'h0C;
    tick();
    chk("tps4_dat_b", dat2, 64'h0B0A0908);
    chk("tps4_k_b", k2, 8'h0C);

    // Out-of-range tps and lanes decode to off / one lane.
    set_cfg(3'd6, 3'd3);
    chk("bad_tps_sta", sta2, 0);
    tick();
    chk("bad_cfg_pass_dat", dat2, 64'h2221);
    chk("bad_cfg_pass_k", k2, 8'h02);

    // Reset mid-TPS2, then a strobe in the reset-release cycle.
    set_cfg(3'd2, 3'd4);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_dat2", dat2, 0);
    chk("midrst_sta", sta2, 0);
    tick();
    rst_n = 1'b1;
    set_cfg(3'd2, 3'd4);
    chk("release_strobe_sta", sta2, 3'd2);
    tick();
    chk("restart_dat2", dat2, {4{16'hCBBC}});
    chk("restart_k2", k2, {4{2'b01}});

`ifdef PRT_DPTX_TRN_ERR_INJ_EN
    set_cfg(3'd1, 3'd4);
    tick();
    err_inj = 1'b1;
    tick();
    err_inj = 1'b0;
    chk("errinj_word", dat2, {{7{8'h4A}}, 8'h4B});
    tick();
    chk("errinj_after", dat2, {8{8'h4A}});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
